// File: rtl/stage_skid_buf.sv
// stage_skid_buf: two-entry skid buffer that follows the 3:1 operand select stage.
//
// Ports:
//   clk        - single clock; all state updates on its rising edge
//   reset      - synchronous, active-high; clears state and both data registers
//   in_data    - operand from the select stage (WIDTH bits)
//   in_valid   - in_data is valid this cycle
//   in_ready   - buffer can accept a word this cycle (registered, low only when full)
//   out_data   - oldest held word; always driven straight from the main register
//   out_valid  - out_data is valid (registered, high when one or two words are held)
//   out_ready  - downstream accepts out_data this cycle
//   count      - occupancy: 0, 1 or 2
//
// The main register always holds the oldest word. The skid register only fills when
// a word arrives while main is occupied and not draining. Because in_ready and
// out_valid are decoded from the state register alone, there is no combinational
// path from in_valid or out_ready to either handshake output.

module stage_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count
);

  // Encoded so that the state value is the occupancy.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic in_fire;
  logic out_fire;

  // Handshake outputs come from registered state only.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    unique case (state_q)
      StEmpty: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      StOne: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      StFull: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  assign out_data = main_q;
  assign count    = state_q;

  // Next-state and data-path steering.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      StEmpty: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = StOne;
        end
      end

      StOne: begin
        if (in_fire && out_fire) begin
          // Head leaves while the new word lands directly in main.
          main_d  = in_data;
          state_d = StOne;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = StFull;
        end else if (out_fire) begin
          // main keeps the departed word; it is don't-care while empty.
          state_d = StEmpty;
        end
      end

      StFull: begin
        // in_ready is low here, so in_fire cannot occur.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end

      default: begin
        state_d = StEmpty;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
